// File: rtl/serial_word_loader_if.sv
// rtl/serial_word_loader_if.sv - serial bit handshake between a bit source and the loader
// Signals:
//   bit_in    : serial data bit, MSB of the word first
//   bit_valid : bit_in is valid this cycle (driven by the source)
//   bit_ready : loader accepts a bit this cycle (driven by the loader)
// Modports: master = bit source, slave = serial_word_loader.
interface serial_word_loader_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - bit-serial MSB-first word assembler feeding a parallel-load register
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   sif         : serial bit handshake (slave side): bit_in, bit_valid, bit_ready
//   d_out       : last good word, drives the register D input
//   load        : one-cycle strobe, drives the register load input
//   busy        : a word is in progress (SHIFT, PAR or LOAD)
//   par_err     : one-cycle pulse after a parity mismatch aborts a word
//   timeout_err : one-cycle pulse after an inter-bit timeout aborts a word
module serial_word_loader #(
    parameter int WIDTH     = 16,
    parameter int PARITY_EN = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_word_loader_if.slave  sif,
    output logic [WIDTH-1:0]     d_out,
    output logic                 load,
    output logic                 busy,
    output logic                 par_err,
    output logic                 timeout_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    // Gap value seen during the TIMEOUT-th consecutive idle cycle.
    localparam logic [15:0]   GAP_LIMIT = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam bit            TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic [15:0]      gap;
    logic             ready_q;

    logic             accept;
    logic             gap_expired;
    logic [WIDTH-1:0] shreg_nxt;

    // ready_q is registered and low only in LOAD, so accept never depends
    // combinationally on an output of this block.
    assign accept      = sif.bit_valid && ready_q;
    assign shreg_nxt   = {shreg[WIDTH-2:0], sif.bit_in};
    assign gap_expired = TO_EN && (gap == GAP_LIMIT);
    assign sif.bit_ready = ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            gap         <= '0;
            d_out       <= '0;
            load        <= 1'b0;
            busy        <= 1'b0;
            par_err     <= 1'b0;
            timeout_err <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            load        <= 1'b0;
            par_err     <= 1'b0;
            timeout_err <= 1'b0;
            ready_q     <= 1'b1;

            case (state)
                IDLE: begin
                    gap <= '0;
                    if (accept) begin
                        shreg <= shreg_nxt;
                        count <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end

                SHIFT, PAR: begin
                    if (accept) begin
                        gap <= '0;
                        if (state == SHIFT) begin
                            shreg <= shreg_nxt;
                            count <= count + CW'(1);
                            if (count == LAST_BIT) begin
                                if (PARITY_EN != 0) begin
                                    state <= PAR;
                                end else begin
                                    state   <= LOAD;
                                    d_out   <= shreg_nxt;
                                    load    <= 1'b1;
                                    ready_q <= 1'b0;
                                end
                            end
                        end else if ((^shreg ^ sif.bit_in) == 1'b0) begin
                            // Even parity over data plus parity bit holds.
                            state   <= LOAD;
                            d_out   <= shreg;
                            load    <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            count   <= '0;
                            par_err <= 1'b1;
                        end
                    end else if (gap_expired) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        count       <= '0;
                        gap         <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end

                default: begin
                    // LOAD: the register captures d_out at this edge.
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                    gap   <= '0;
                end
            endcase
        end
    end

endmodule
